// File: rtl/serial_subtractor_if.sv
// Request/result bundle of the bit-serial subtractor.
// The requester holds the master side; the subtractor holds the slave side.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             bit_vld;
    logic             bit_out;

    modport master (
        output start, a, b,
        input  busy, done, diff, bout, bit_vld, bit_out
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, bout, bit_vld, bit_out
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: a - b, LSB first.
// One full-subtractor cell per clock, with the borrow registered between bits.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_diff;
    logic [CW-1:0]    r_cnt;
    logic             r_br;
    logic             r_bout;
    logic             r_busy;
    logic             r_done;

    logic             w_run;
    logic             w_d;
    logic             w_bn;

    // Full-subtractor cell working on the current LSBs of the shift registers.
    assign w_run = (r_state == RUN);
    assign w_d   = r_sa[0] ^ r_sb[0] ^ r_br;
    assign w_bn  = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_br);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_diff  <= '0;
            r_cnt   <= '0;
            r_br    <= 1'b0;
            r_bout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_sa    <= bus.a;
                        r_sb    <= bus.b;
                        r_br    <= 1'b0;
                        r_cnt   <= '0;
                        r_diff  <= '0;
                        r_bout  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_sa   <= r_sa >> 1;
                    r_sb   <= r_sb >> 1;
                    r_diff <= {w_d, r_diff[WIDTH-1:1]};
                    r_br   <= w_bn;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_bout  <= w_bn;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Serial outputs decode straight from state and datapath; bit_out is forced low outside RUN.
    assign bus.bit_vld = w_run;
    assign bus.bit_out = w_run & w_d;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.diff    = r_diff;
    assign bus.bout    = r_bout;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor (WIDTH = 8).
// Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
module tb_serial_subtractor;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   n_done;
    int   n_expect_done;

    serial_subtractor_if #(.WIDTH(W)) sif ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && sif.done === 1'b1) n_done++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete operation; expectations come from the bench's own values.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_diff, input logic exp_bout,
                          input bit verbose);
        @(posedge clk); #1;
        sif.start = 1'b1; sif.a = a; sif.b = b;
        @(posedge clk); #1;
        sif.start = 1'b0; sif.a = ~a; sif.b = ~b;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check("busy_run", {31'd0, sif.busy}, 32'd1);
            check("bit_vld", {31'd0, sif.bit_vld}, 32'd1);
            check("bit_out", {31'd0, sif.bit_out}, {31'd0, exp_diff[i]});
            check("done_early", {31'd0, sif.done}, 32'd0);
            @(posedge clk);
        end
        @(negedge clk);
        check("done_pulse", {31'd0, sif.done}, 32'd1);
        check("busy_done", {31'd0, sif.busy}, 32'd0);
        check("diff", {24'd0, sif.diff}, {24'd0, exp_diff});
        check("bout", {31'd0, sif.bout}, {31'd0, exp_bout});
        @(negedge clk);
        check("done_once", {31'd0, sif.done}, 32'd0);
        check("diff_held", {24'd0, sif.diff}, {24'd0, exp_diff});
        n_expect_done++;
        if (verbose)
            $display("op a=%0d b=%0d diff=%0h bout=%0b", a, b, sif.diff, sif.bout);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic [W:0]   ref_v;
        checks = 0; errors = 0; n_done = 0; n_expect_done = 0;
        rst_n = 1'b0;
        sif.start = 1'b0; sif.a = '0; sif.b = '0;
        #2;
        check("rst_busy", {31'd0, sif.busy}, 32'd0);
        check("rst_done", {31'd0, sif.done}, 32'd0);
        check("rst_diff", {24'd0, sif.diff}, 32'd0);
        check("rst_bout", {31'd0, sif.bout}, 32'd0);
        check("rst_bit_vld", {31'd0, sif.bit_vld}, 32'd0);
        check("rst_bit_out", {31'd0, sif.bit_out}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed vectors, hand-computed.
        run_op(8'd100, 8'd37, 8'd63, 1'b0, 1'b1);
        run_op(8'd5, 8'd10, 8'hFB, 1'b1, 1'b1);
        run_op(8'hA5, 8'hA5, 8'h00, 1'b0, 1'b1);
        run_op(8'd0, 8'd1, 8'hFF, 1'b1, 1'b1);
        run_op(8'hFF, 8'h00, 8'hFF, 1'b0, 1'b1);
        run_op(8'h80, 8'h7F, 8'h01, 1'b0, 1'b1);
        run_op(8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1);

        // Start held high: back-to-back acceptance every W+2 cycles, mid-run inputs ignored.
        @(posedge clk); #1;
        sif.start = 1'b1; sif.a = 8'd20; sif.b = 8'd3;
        @(posedge clk); #1;
        sif.a = 8'd200; sif.b = 8'd100;
        repeat (W) @(posedge clk);
        @(negedge clk);
        check("hold_done1", {31'd0, sif.done}, 32'd1);
        check("hold_diff1", {24'd0, sif.diff}, 32'd17);
        check("hold_bout1", {31'd0, sif.bout}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("hold_idle_gap", {31'd0, sif.busy}, 32'd0);
        @(posedge clk); #1;
        sif.a = 8'd1; sif.b = 8'd2;
        @(negedge clk);
        check("hold_accept2", {31'd0, sif.busy}, 32'd1);
        check("hold_diff_clr", {24'd0, sif.diff}, 32'd0);
        sif.start = 1'b0;
        repeat (W) @(posedge clk);
        @(negedge clk);
        check("hold_done2", {31'd0, sif.done}, 32'd1);
        check("hold_diff2", {24'd0, sif.diff}, 32'd100);
        check("hold_bout2", {31'd0, sif.bout}, 32'd0);
        n_expect_done += 2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("hold_stop", {31'd0, sif.busy}, 32'd0);
        $display("hold-start ops diff1=17 diff2=%0d", sif.diff);

        // Reset during RUN cycle 4 aborts with no done.
        @(posedge clk); #1;
        sif.start = 1'b1; sif.a = 8'd9; sif.b = 8'd4;
        @(posedge clk); #1;
        sif.start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, sif.busy}, 32'd0);
        check("abort_bit_vld", {31'd0, sif.bit_vld}, 32'd0);
        check("abort_bit_out", {31'd0, sif.bit_out}, 32'd0);
        check("abort_diff", {24'd0, sif.diff}, 32'd0);
        check("abort_bout", {31'd0, sif.bout}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (W + 2) @(negedge clk);
        check("abort_no_done", n_done, n_expect_done);
        check("abort_idle", {31'd0, sif.busy}, 32'd0);
        $display("reset abort checked");
        run_op(8'd9, 8'd4, 8'd5, 1'b0, 1'b1);

        // Random operands against a 9-bit borrow-extended reference.
        for (int k = 0; k < 200; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            ref_v = {1'b0, ra} - {1'b0, rb};
            run_op(ra, rb, ref_v[W-1:0], ref_v[W], 1'b1);
        end

        repeat (2) @(negedge clk);
        check("done_count", n_done, n_expect_done);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
